// File: rtl/frame_field_sequencer.sv
//==============================================================================
// Module      : frame_field_sequencer
// Description : Steps through the fields of a CAN-style frame one bit time at
//               a time. It accepts a transmit request, captures the frame
//               shape (remote flag and data length), and reports the current
//               field, the bit position within it, and field/frame completion.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_field_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       Tx_request,
    input  logic       remote_req,
    input  logic [3:0] dlc,
    input  logic       abort,
    output logic       tx_ack,
    output logic [3:0] field,
    output logic [6:0] bit_index,
    output logic       field_done,
    output logic       frame_done,
    output logic       busy,
    output logic       rtr_value,
    output logic [6:0] data_bits
);

    typedef enum logic [3:0] {
        c_IDLE    = 4'd0,
        c_SOF     = 4'd1,
        c_ID      = 4'd2,
        c_RTR     = 4'd3,
        c_CTRL    = 4'd4,
        c_DATA    = 4'd5,
        c_CRC     = 4'd6,
        c_CRC_DEL = 4'd7,
        c_ACK     = 4'd8,
        c_EOF     = 4'd9,
        c_IFS     = 4'd10
    } field_t;

    localparam logic [3:0] c_LAST_CODE = 4'd10;

    field_t     r_field;
    logic [6:0] r_bit_index;
    logic       r_tx_ack;
    logic       r_field_done;
    logic       r_frame_done;
    logic       r_rtr_value;
    logic [6:0] r_data_bits;

    logic [6:0] w_len;
    logic [6:0] w_req_data_bits;
    logic       w_field_valid;
    logic       w_last_bit;
    field_t     w_next_field;

    // Length in bits of the field currently being sent.
    always_comb begin
        w_len = 7'd1;
        case (r_field)
            c_SOF:     w_len = 7'd1;
            c_ID:      w_len = 7'd11;
            c_RTR:     w_len = 7'd1;
            c_CTRL:    w_len = 7'd6;
            c_DATA:    w_len = r_data_bits;
            c_CRC:     w_len = 7'd15;
            c_CRC_DEL: w_len = 7'd1;
            c_ACK:     w_len = 7'd2;
            c_EOF:     w_len = 7'd7;
            c_IFS:     w_len = 7'd3;
            default:   w_len = 7'd1;
        endcase
    end

    // Field that follows the current one; DATA is skipped for empty payloads.
    always_comb begin
        w_next_field = c_IDLE;
        case (r_field)
            c_SOF:     w_next_field = c_ID;
            c_ID:      w_next_field = c_RTR;
            c_RTR:     w_next_field = c_CTRL;
            c_CTRL:    w_next_field = (r_data_bits == 7'd0) ? c_CRC : c_DATA;
            c_DATA:    w_next_field = c_CRC;
            c_CRC:     w_next_field = c_CRC_DEL;
            c_CRC_DEL: w_next_field = c_ACK;
            c_ACK:     w_next_field = c_EOF;
            c_EOF:     w_next_field = c_IFS;
            default:   w_next_field = c_IDLE;
        endcase
    end

    // Payload length: remote frames carry none, otherwise 8 bits per byte, max 8 bytes.
    assign w_req_data_bits = remote_req ? 7'd0 :
                             (dlc[3] ? 7'd64 : {1'b0, dlc[2:0], 3'b000});

    assign w_field_valid = (r_field <= c_LAST_CODE);
    assign w_last_bit    = (r_bit_index >= (w_len - 7'd1));

    // Sequencer state: abort/illegal-code recovery first, then qualified bit steps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_field      <= c_IDLE;
            r_bit_index  <= 7'd0;
            r_tx_ack     <= 1'b0;
            r_field_done <= 1'b0;
            r_frame_done <= 1'b0;
            r_rtr_value  <= 1'b0;
            r_data_bits  <= 7'd0;
        end else begin
            r_tx_ack     <= 1'b0;
            r_field_done <= 1'b0;
            r_frame_done <= 1'b0;
            if (abort || !w_field_valid) begin
                r_field     <= c_IDLE;
                r_bit_index <= 7'd0;
            end else if (enable && sample_point) begin
                if (r_field == c_IDLE) begin
                    if (Tx_request) begin
                        r_field     <= c_SOF;
                        r_bit_index <= 7'd0;
                        r_rtr_value <= remote_req;
                        r_data_bits <= w_req_data_bits;
                        r_tx_ack    <= 1'b1;
                    end
                end else if (!w_last_bit) begin
                    r_bit_index <= r_bit_index + 7'd1;
                end else begin
                    r_field      <= w_next_field;
                    r_bit_index  <= 7'd0;
                    r_field_done <= 1'b1;
                    r_frame_done <= (r_field == c_IFS);
                end
            end
        end
    end

    assign field      = r_field;
    assign bit_index  = r_bit_index;
    assign tx_ack     = r_tx_ack;
    assign field_done = r_field_done;
    assign frame_done = r_frame_done;
    assign busy       = (r_field != c_IDLE);
    assign rtr_value  = r_rtr_value;
    assign data_bits  = r_data_bits;

endmodule

`default_nettype wire

// File: doc/frame_field_sequencer.md
FRAME_FIELD_SEQUENCER -- requirements
Module: frame_field_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The ports SHALL be, in order:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous active-high reset.
- enable  input  1  high = sequencer runs; low = all state frozen.
- sample_point  input  1  one-cycle bit-time strobe; each field bit is consumed on a cycle where it is high.
- Tx_request  input  1  level request to transmit a frame.
- remote_req  input  1  1 = remote frame; captured with the request.
- dlc  input  4  data length code; captured with the request.
- abort  input  1  error/arbitration-loss abort.
- tx_ack  output  1  one-cycle pulse: request accepted.
- field  output  4  current field code.
- bit_index  output  7  bit position within the current field, counting up from 0.
- field_done  output  1  one-cycle pulse after a field's last bit.
- frame_done  output  1  one-cycle pulse after the frame's last bit.
- busy  output  1  high whenever field != IDLE.
- rtr_value  output  1  captured remote_req, drives the RTR field block.
- data_bits  output  7  captured data-field length in bits.

Function
REQ-003 Field codes and lengths in bits SHALL be:
- IDLE=0 (no length), SOF=1 (1), ID=2 (11), RTR=3 (1), CTRL=4 (6).
- DATA=5 (data_bits), CRC=6 (15), CRC_DEL=7 (1), ACK=8 (2), EOF=9 (7), IFS=10 (3).
REQ-004 Codes 11-15 SHALL be unreachable; if one is ever present, the next clock edge SHALL force IDLE.
REQ-005 All updates SHALL occur only on edges where enable=1 and sample_point=1; abort and reset are the exceptions.
REQ-006 Request acceptance:
- Condition: IDLE, enable=1, sample_point=1, Tx_request=1.
- On that edge: enter SOF with bit_index=0, capture rtr_value=remote_req, capture data_bits.
- On the following cycle: pulse tx_ack.
REQ-007 Data length calculation:
- data_bits = 0 if remote_req=1.
- Otherwise data_bits = 8*min(dlc,8), so dlc 9-15 clamp to 64.
- The result is 7 bits wide and has no overflow.
REQ-008 Bit stepping, on a qualifying edge:
- If bit_index < length-1, increment bit_index.
- Otherwise advance to the next field, reset bit_index to 0, and pulse field_done on the following cycle.
REQ-009 Field order SHALL be SOF, ID, RTR, CTRL, DATA, CRC, CRC_DEL, ACK, EOF, IFS, IDLE.
REQ-010 When data_bits=0, CTRL SHALL go directly to CRC and DATA SHALL never be entered.
REQ-011 When IFS completes, the block SHALL return to IDLE and pulse frame_done together with field_done.
REQ-012 A new request SHALL be accepted only at a later sample_point while in IDLE; back-to-back frames are therefore separated by at least 1 IDLE bit time.
REQ-013 Abort:
- abort=1 on any edge, regardless of enable or sample_point, SHALL force IDLE with bit_index=0.
- Abort SHALL NOT pulse field_done or frame_done.
- Abort SHALL cancel a pending tx_ack.
REQ-014 Abort SHALL have priority over bit stepping and over request acceptance on the same edge.
REQ-015 With enable=0, field and bit_index SHALL hold, and tx_ack, field_done and frame_done SHALL stay 0.
REQ-016 With enable=0, sample_point strobes SHALL be ignored, not queued.
REQ-017 Changes to dlc and remote_req during a frame SHALL have no effect on the frame in progress.
REQ-018 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-019 While reset=1, the outputs SHALL be: field=0 (IDLE), bit_index=0, tx_ack=0, field_done=0, frame_done=0, busy=0, rtr_value=0, data_bits=0.
REQ-020 Reset asserted mid-frame SHALL immediately return the block to IDLE and SHALL produce no pulses.
REQ-021 After reset is released, operation SHALL resume at the first qualifying sample_point.

Verification
REQ-022 Data frame:
- Stimulus: dlc=2, remote_req=0.
- Response: tx_ack once, data_bits=16, frame_done after exactly 63 sample_points, 10 field_done pulses, field sequence 1..10 then 0.
REQ-023 Remote frame:
- Stimulus: dlc=8, remote_req=1.
- Response: rtr_value=1, data_bits=0, field goes 4 to 6, frame_done after 47 sample_points, 9 field_done pulses.
REQ-024 Clamped frame:
- Stimulus: dlc=15, remote_req=0.
- Response: data_bits=64, frame_done after 111 sample_points.
REQ-025 Enable freeze:
- Stimulus: enable=0 for 5 sample_points while field=2, bit_index=4.
- Response: values hold at 2/4, no pulses; after re-enable, frame_done arrives exactly 5 sample_points later than in the uninterrupted case.
REQ-026 Abort:
- Stimulus: abort during DATA, coincident with sample_point and Tx_request=1.
- Response: field=0 next cycle, no field_done or frame_done; a new frame is accepted at the next sample_point.
REQ-027 Reset:
- Stimulus: reset asserted during CRC.
- Response: all outputs at reset values while reset=1; a fresh frame runs normally after release.
